// File: rtl/div_pkg.sv
// div_pkg: shared state encoding, default width and counter preset for divider48_24.
// Exports: state_t, DIV_N, CNT_INIT, cnt_init().
// Used by divider48_24, divider48_24_dp and divider48_24_cu.
package div_pkg;

  localparam int DIV_N = 24;

  // The iteration counter is 5 bits and runs up to all-ones, so it is preset
  // to 32-N to give exactly N iterations.
  localparam logic [4:0] CNT_INIT = 5'(32 - DIV_N);

  // Idle..Check keep their 2-bit codes; Div needs a fifth code, hence 3 bits.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_LOAD  = 3'd2,
    S_CHECK = 3'd3,
    S_DIV   = 3'd4
  } state_t;

  function automatic logic [4:0] cnt_init(input int n);
    return 5'(32 - n);
  endfunction

endpackage

// File: rtl/divider48_24_cu.sv
// divider48_24_cu: start/ready handshake FSM and 5-bit iteration counter.
// Ports: clk, rst, start, ge from the datapath; issues load_rq, load_d, shift_rq,
//        set_ovf, clr_ovf, init_cnt and the Moore ready output (high only in Idle).
module divider48_24_cu
  import div_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic ge,
  output logic load_rq,
  output logic load_d,
  output logic shift_rq,
  output logic set_ovf,
  output logic clr_ovf,
  output logic init_cnt,
  output logic ready
);

  state_t     state;
  state_t     state_nxt;
  logic [4:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (init_cnt) begin
      cnt <= cnt_init(N);
    end else if (shift_rq) begin
      cnt <= cnt + 5'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    load_rq   = 1'b0;
    load_d    = 1'b0;
    shift_rq  = 1'b0;
    set_ovf   = 1'b0;
    clr_ovf   = 1'b0;
    init_cnt  = 1'b0;
    case (state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) begin
          state_nxt = S_INIT;
        end
      end
      S_INIT: begin
        init_cnt = 1'b1;
        clr_ovf  = 1'b1;
        // The operation launches only once the requester drops start.
        if (!start) begin
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        load_rq   = 1'b1;
        load_d    = 1'b1;
        state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if (ge) begin
          set_ovf   = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_DIV;
        end
      end
      S_DIV: begin
        shift_rq = 1'b1;
        // Last iteration happens on the edge where the counter is all ones.
        if (cnt == 5'h1f) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/divider48_24_dp.sv
// divider48_24_dp: divisor/remainder/quotient registers, restoring subtractor, overflow flag.
// Ports: clk, rst, dividend, divisor, strobes from the controller (load_rq, load_d,
//        shift_rq, set_ovf, clr_ovf); outputs quotient, remainder, ovf and ge (rreg >= dreg).
module divider48_24_dp
  import div_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  input  logic           load_rq,
  input  logic           load_d,
  input  logic           shift_rq,
  input  logic           set_ovf,
  input  logic           clr_ovf,
  output logic [N-1:0]   quotient,
  output logic [N-1:0]   remainder,
  output logic           ovf,
  output logic           ge
);

  logic [N-1:0] dreg;
  logic [N-1:0] rreg;
  logic [N-1:0] qreg;
  logic         ovf_q;

  logic [N:0]   shifted;
  logic [N+1:0] diff;
  logic         borrow;

  // Next dividend bit moves from the top of qreg into the partial remainder.
  assign shifted = {rreg, qreg[N-1]};
  assign diff    = {1'b0, shifted} - {2'b00, dreg};
  assign borrow  = diff[N+1];

  // High half >= divisor means the quotient cannot fit in N bits; divisor 0 lands here too.
  assign ge = (rreg >= dreg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dreg  <= '0;
      rreg  <= '0;
      qreg  <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (load_d) begin
        dreg <= divisor;
      end
      if (load_rq) begin
        rreg <= dividend[2*N-1:N];
        qreg <= dividend[N-1:0];
      end else if (set_ovf) begin
        rreg <= '0;
        qreg <= '1;
      end else if (shift_rq) begin
        // rreg < dreg holds throughout, so the restored or reduced value fits in N bits.
        rreg <= borrow ? shifted[N-1:0] : diff[N-1:0];
        qreg <= {qreg[N-2:0], ~borrow};
      end
      if (set_ovf) begin
        ovf_q <= 1'b1;
      end else if (clr_ovf) begin
        ovf_q <= 1'b0;
      end
    end
  end

  assign quotient  = qreg;
  assign remainder = rreg;
  assign ovf       = ovf_q;

endmodule

// File: rtl/divider48_24.sv
// divider48_24: sequential restoring divider, 2N-bit dividend / N-bit divisor, one quotient bit per clock.
// Ports: clk, rst (async, active-high), start, dividend, divisor -> quotient, remainder, ovf, ready.
// Result valid while ready=1 after a run: N+3 cycles after start falls, 3 cycles on overflow/divide-by-zero.
module divider48_24
  import div_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic [N-1:0]   quotient,
  output logic [N-1:0]   remainder,
  output logic           ovf,
  output logic           ready
);

  logic load_rq;
  logic load_d;
  logic shift_rq;
  logic set_ovf;
  logic clr_ovf;
  logic init_cnt;
  logic ge;

  divider48_24_dp #(.N(N)) u_dp (
    .clk      (clk),
    .rst      (rst),
    .dividend (dividend),
    .divisor  (divisor),
    .load_rq  (load_rq),
    .load_d   (load_d),
    .shift_rq (shift_rq),
    .set_ovf  (set_ovf),
    .clr_ovf  (clr_ovf),
    .quotient (quotient),
    .remainder(remainder),
    .ovf      (ovf),
    .ge       (ge)
  );

  divider48_24_cu #(.N(N)) u_cu (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .ge       (ge),
    .load_rq  (load_rq),
    .load_d   (load_d),
    .shift_rq (shift_rq),
    .set_ovf  (set_ovf),
    .clr_ovf  (clr_ovf),
    .init_cnt (init_cnt),
    .ready    (ready)
  );

endmodule
